// File: rtl/cpsr_cond_unit.sv
// ARM-style condition check with a one-deep pending CPSR flag update.
// S-bit instructions that pass their condition make the block wait for the ALU flags.
`timescale 1ns/1ps

module cpsr_cond_unit #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] instr_cond,
  input  logic       instr_set_flags,
  input  logic [3:0] alu_flags,
  input  logic       flags_valid,
  output logic       instr_ready,
  output logic       exec_en,
  output logic       skip,
  output logic [3:0] cpsr_flags,
  output logic       flags_pending,
  output logic       flag_err
);

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // A WAIT cycle that starts with the counter here is the WAIT_MAX-th one without flags.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  // Flag vector layout: [0]=Z, [1]=C, [2]=N, [3]=V.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[0];
    c = f[1];
    n = f[2];
    v = f[3];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       cpsr_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             err_nxt;
  logic [3:0]       eff_flags;
  logic             accept;
  logic             pass;
  logic             set_req;

  assign instr_ready   = (state == ST_IDLE) ? 1'b1 : flags_valid;
  assign flags_pending = (state == ST_WAIT);

  // Arriving ALU flags are forwarded to an instruction accepted in the same cycle.
  assign eff_flags = ((state == ST_WAIT) && flags_valid) ? alu_flags : cpsr_flags;
  assign accept    = instr_valid && instr_ready;
  assign pass      = cond_pass(instr_cond, eff_flags);
  assign set_req   = accept && pass && instr_set_flags;

  // NOTE: every output of this block gets a default first so no path holds a stale value (no latches).
  always_comb begin
    state_nxt = state;
    cpsr_nxt  = cpsr_flags;
    cnt_nxt   = wait_cnt;
    err_nxt   = flag_err;
    case (state)
      ST_IDLE: begin
        // Flags with nothing pending are a protocol error and are dropped.
        if (flags_valid) begin
          err_nxt = 1'b1;
        end
        if (set_req) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (flags_valid) begin
          cpsr_nxt = alu_flags;
          if (set_req) begin
            cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (wait_cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cpsr_flags <= 4'b0000;
      wait_cnt   <= '0;
      flag_err   <= 1'b0;
      exec_en    <= 1'b0;
      skip       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpsr_flags <= cpsr_nxt;
      wait_cnt   <= cnt_nxt;
      flag_err   <= err_nxt;
      exec_en    <= accept && pass;
      skip       <= accept && !pass;
    end
  end

endmodule

// File: tb/tb_cpsr_cond_unit.sv
// Self-checking bench for cpsr_cond_unit: vector table plus timeout and reset sequences.
`timescale 1ns/1ps

module tb_cpsr_cond_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [3:0] instr_cond = 4'h0;
  logic       instr_set_flags = 1'b0;
  logic [3:0] alu_flags = 4'h0;
  logic       flags_valid = 1'b0;
  logic       instr_ready;
  logic       exec_en;
  logic       skip;
  logic [3:0] cpsr_flags;
  logic       flags_pending;
  logic       flag_err;

  cpsr_cond_unit #(.WAIT_MAX(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_cond     (instr_cond),
    .instr_set_flags(instr_set_flags),
    .alu_flags      (alu_flags),
    .flags_valid    (flags_valid),
    .instr_ready    (instr_ready),
    .exec_en        (exec_en),
    .skip           (skip),
    .cpsr_flags     (cpsr_flags),
    .flags_pending  (flags_pending),
    .flag_err       (flag_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       sflag;
    logic       fv;
    logic [3:0] alu;
    logic       ready;
    logic       ex;
    logic       sk;
    logic [3:0] cpsr;
    logic       pend;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic       ex;
    logic       sk;
    logic [3:0] cpsr;
    logic       pend;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic [3:0] cond, input logic sflag,
                              input logic fv, input logic [3:0] alu, input logic ready,
                              input logic ex, input logic sk, input logic [3:0] cpsr,
                              input logic pend, input logic err);
    vec_t v;
    v = '{valid, cond, sflag, fv, alu, ready, ex, sk, cpsr, pend, err};
    return v;
  endfunction

  // Called at a falling edge: drive, check ready, clock, then compare registered outputs.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    instr_valid     = v.valid;
    instr_cond      = v.cond;
    instr_set_flags = v.sflag;
    flags_valid     = v.fv;
    alu_flags       = v.alu;
    #1;
    check({name, ".ready"}, instr_ready, v.ready);
    sb_q.push_back('{v.ex, v.sk, v.cpsr, v.pend, v.err});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({name, ".sb_underflow"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({name, ".exec_en"}, exec_en, e.ex);
      check({name, ".skip"}, skip, e.sk);
      check({name, ".cpsr"}, cpsr_flags, e.cpsr);
      check({name, ".pending"}, flags_pending, e.pend);
      check({name, ".flag_err"}, flag_err, e.err);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    instr_valid     = 1'b0;
    instr_cond      = 4'h0;
    instr_set_flags = 1'b0;
    flags_valid     = 1'b0;
    alu_flags       = 4'h0;
    reset           = 1'b1;
    #1;
    check({name, ".exec_en"}, exec_en, 0);
    check({name, ".skip"}, skip, 0);
    check({name, ".cpsr"}, cpsr_flags, 0);
    check({name, ".pending"}, flags_pending, 0);
    check({name, ".flag_err"}, flag_err, 0);
    check({name, ".ready"}, instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle_wait;
    // After reset flags are 0000.
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h0, 1, 0, 1, 4'h0, 0, 0)); // EQ skips
    vecs.push_back(mk(1, 4'h1, 0, 0, 4'h0, 1, 1, 0, 4'h0, 0, 0)); // NE executes
    vecs.push_back(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'h0, 1, 0)); // AL S=1 -> WAIT
    vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0)); // waiting, not ready
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0)); // offer stalls in WAIT
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'h1, 1, 0, 0, 4'h1, 0, 0)); // flags 0001 -> IDLE
    vecs.push_back(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'h1, 1, 0)); // AL S=1
    vecs.push_back(mk(1, 4'h0, 0, 1, 4'h0, 1, 0, 1, 4'h0, 0, 0)); // EQ bypass Z=0 skips
    vecs.push_back(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'h0, 1, 0)); // AL S=1
    vecs.push_back(mk(1, 4'h0, 0, 1, 4'h1, 1, 1, 0, 4'h1, 0, 0)); // EQ bypass Z=1 executes
    vecs.push_back(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'h1, 1, 0)); // AL S=1
    vecs.push_back(mk(1, 4'hE, 1, 1, 4'h4, 1, 1, 0, 4'h4, 1, 0)); // back-to-back S stays WAIT
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'h4, 1, 0, 0, 4'h4, 0, 0)); // flags 0100 -> IDLE
    // N=1 V=0 Z=0 C=0
    vecs.push_back(mk(1, 4'hA, 0, 0, 4'h0, 1, 0, 1, 4'h4, 0, 0)); // GE skips
    vecs.push_back(mk(1, 4'hB, 0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 0)); // LT executes
    vecs.push_back(mk(1, 4'hD, 0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 0)); // LE executes
    vecs.push_back(mk(1, 4'hC, 0, 0, 4'h0, 1, 0, 1, 4'h4, 0, 0)); // GT skips
    vecs.push_back(mk(1, 4'hF, 1, 0, 4'h0, 1, 0, 1, 4'h4, 0, 0)); // NV S=1 skips, no WAIT
    vecs.push_back(mk(1, 4'h4, 0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 0)); // MI executes
    vecs.push_back(mk(1, 4'h5, 0, 0, 4'h0, 1, 0, 1, 4'h4, 0, 0)); // PL skips
    vecs.push_back(mk(1, 4'h2, 0, 0, 4'h0, 1, 0, 1, 4'h4, 0, 0)); // CS skips
    vecs.push_back(mk(1, 4'h9, 0, 0, 4'h0, 1, 1, 0, 4'h4, 0, 0)); // LS executes
    vecs.push_back(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'h4, 1, 0)); // AL S=1
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'hA, 1, 0, 0, 4'hA, 0, 0)); // flags 1010
    // V=1 N=0 C=1 Z=0
    vecs.push_back(mk(1, 4'h6, 0, 0, 4'h0, 1, 1, 0, 4'hA, 0, 0)); // VS executes
    vecs.push_back(mk(1, 4'h7, 0, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // VC skips
    vecs.push_back(mk(1, 4'h8, 0, 0, 4'h0, 1, 1, 0, 4'hA, 0, 0)); // HI executes
    vecs.push_back(mk(1, 4'h3, 0, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // CC skips
    vecs.push_back(mk(1, 4'hA, 0, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // GE skips
    vecs.push_back(mk(1, 4'hC, 0, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // GT skips
    vecs.push_back(mk(1, 4'h0, 0, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // EQ skips
    vecs.push_back(mk(1, 4'h7, 1, 0, 4'h0, 1, 0, 1, 4'hA, 0, 0)); // VC S=1 skips, no WAIT

    @(negedge clk);
    do_reset("reset0");
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Timeout: 14 flagless WAIT cycles stay pending, the 15th times out.
    apply(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'hA, 1, 0), "to_enter");
    for (int k = 1; k <= 14; k++) begin
      idle_wait = mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hA, 1, 0);
      apply(idle_wait, $sformatf("to_wait%0d", k));
    end
    apply(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hA, 0, 1), "to_expire");
    apply(mk(0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'hA, 0, 1), "to_sticky0");
    apply(mk(0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'hA, 0, 1), "to_sticky1");
    apply(mk(1, 4'h1, 0, 0, 4'h0, 1, 1, 0, 4'hA, 0, 1), "to_ne_after");

    // Reset in the middle of WAIT drops the pending update and clears the error.
    apply(mk(1, 4'hE, 1, 0, 4'h0, 1, 1, 0, 4'hA, 1, 1), "mid_enter");
    apply(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 4'hA, 1, 1), "mid_wait");
    do_reset("reset_mid");
    apply(mk(1, 4'h0, 0, 0, 4'h0, 1, 0, 1, 4'h0, 0, 0), "post_eq");
    apply(mk(1, 4'h1, 0, 0, 4'h0, 1, 1, 0, 4'h0, 0, 0), "post_ne");

    // Flags arriving in IDLE are ignored and flag an error.
    apply(mk(0, 4'h0, 0, 1, 4'hF, 1, 0, 0, 4'h0, 0, 1), "idle_fv");
    apply(mk(0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 4'h0, 0, 1), "idle_fv_hold");

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
